// File: rtl/router_pkg.sv
// Shared types for the router ingress path: packet layout, byte index and
// reassembly FSM state encoding.
package router_pkg;

  localparam int BYTES_PER_PKT = 4;

  typedef struct packed {
    logic [3:0]  source_id;
    logic [3:0]  dest_id;
    logic [23:0] data;
  } pkt_t;

  typedef logic [1:0] byte_idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic logic is_last_byte(input byte_idx_t idx);
    return idx == byte_idx_t'(BYTES_PER_PKT - 1);
  endfunction

endpackage

// File: rtl/router_ingress_port_if.sv
// Endpoint->router byte link plus the packet stream towards the switch core.
// master = endpoint/switch side, slave = router ingress port.
interface router_ingress_port_if;

  logic               free_outbound;
  logic               put_outbound;
  logic [7:0]         payload_outbound;
  router_pkg::pkt_t   pkt_out;
  logic               pkt_out_valid;
  logic               pkt_out_ready;

  modport master (
    input  free_outbound,
    output put_outbound,
    output payload_outbound,
    input  pkt_out,
    input  pkt_out_valid,
    output pkt_out_ready
  );

  modport slave (
    output free_outbound,
    input  put_outbound,
    input  payload_outbound,
    output pkt_out,
    output pkt_out_valid,
    input  pkt_out_ready
  );

endinterface

// File: rtl/router_ingress_port_fifo.sv
// Show-ahead packet FIFO: head is the registered entry at the read pointer,
// simultaneous push and pop are both honoured.
module pkt_fifo
  import router_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pkt_t
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO may still accept a write into the slot being popped
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/router_ingress_port.sv
// Router ingress port: reassembles four link bytes into a pkt_t, buffers it
// and offers it to the switch core. Optional stall timeout: ROUTER_INGRESS_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for byte0; accepted only while free_outbound is 1
// RECV  | bytes 1..3 outstanding; a FIFO slot is reserved
module router_ingress_port
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  router_ingress_port_if.slave  lnk,
  output logic                  proto_err,
  output logic                  drop
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_RECV = 1'(RECV);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("router_ingress_port: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  logic [0:0]    state_q, state_d;
  byte_idx_t     idx_q, idx_d;
  logic [31:0]   asm_q;
  logic          push_pend_q, push_pend_d;
  logic          free_q, free_d;
  logic          proto_err_q;
  logic          capture;
  logic          pop;
  logic          timeout;
  logic [CW-1:0] fifo_count, count_d;
  logic          fifo_empty, fifo_full;
  pkt_t          fifo_head;
  logic [CW:0]   reserved_d;

  assign pop = !fifo_empty && lnk.pkt_out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    push_pend_d = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lnk.put_outbound && free_q) begin
          capture = 1'b1;
          state_d = S_RECV;
          idx_d   = byte_idx_t'(1);
        end
      end
      default: begin
        if (lnk.put_outbound) begin
          capture = 1'b1;
          if (is_last_byte(idx_q)) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            push_pend_d = 1'b1;
          end else begin
            idx_d = idx_q + byte_idx_t'(1);
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
    endcase
  end

  // The completed packet is pushed one cycle after byte3, so the pending push
  // must keep holding its slot in the reservation until the FIFO counts it.
  always_comb begin
    count_d    = fifo_count + CW'(push_pend_q) - CW'(pop);
    reserved_d = (CW+1)'(count_d) + (CW+1)'(push_pend_d) + (CW+1)'(state_d == S_RECV);
    free_d     = reserved_d < (CW+1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      push_pend_q <= 1'b0;
      free_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      push_pend_q <= push_pend_d;
      free_q      <= free_d;
      proto_err_q <= (state_q == S_IDLE) && lnk.put_outbound && !free_q;
      if (capture) asm_q <= {asm_q[23:0], lnk.payload_outbound};
    end
  end

`ifdef ROUTER_INGRESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] stall_q;
  logic          drop_q;

  assign timeout = (state_q == S_RECV) && !lnk.put_outbound && (stall_q == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_q <= TW'(TIMEOUT - 1);
      drop_q  <= 1'b0;
    end else begin
      drop_q <= timeout;
      if (state_q != S_RECV || lnk.put_outbound) stall_q <= TW'(TIMEOUT - 1);
      else if (stall_q != '0)                    stall_q <= stall_q - TW'(1);
    end
  end

  assign drop = drop_q;
`else
  assign timeout = 1'b0;
  assign drop    = 1'b0;
`endif

  pkt_fifo #(
    .DEPTH (DEPTH),
    .T     (pkt_t)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_pend_q),
    .push_data (pkt_t'(asm_q)),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign lnk.free_outbound = free_q;
  assign lnk.pkt_out_valid = !fifo_empty;
  assign lnk.pkt_out       = fifo_empty ? pkt_t'('0) : fifo_head;
  assign proto_err         = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst_b) assert (!(fifo_full && free_q));
  end

endmodule

// File: tb/tb_router_ingress_port.sv
// Directed bench for router_ingress_port; the timeout scenario runs only when
// ROUTER_INGRESS_TIMEOUT_EN is defined.
module tb_router_ingress_port;

  logic clk = 1'b0;
  logic rst_b;
  logic proto_err;
  logic drop;
  int   checks = 0;
  int   errors = 0;
  int   proto_cnt = 0;
  int   drop_cnt = 0;

  router_ingress_port_if lnk();

  router_ingress_port #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .lnk       (lnk),
    .proto_err (proto_err),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (proto_err === 1'b1) proto_cnt++;
    if (drop === 1'b1) drop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    lnk.put_outbound     = 1'b1;
    lnk.payload_outbound = b;
    tick();
    lnk.put_outbound     = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    for (int i = 0; i < 4; i++) send_byte(p[31-8*i -: 8]);
  endtask

  task automatic test_reset();
    rst_b                = 1'b0;
    lnk.put_outbound     = 1'b0;
    lnk.payload_outbound = 8'h00;
    lnk.pkt_out_ready    = 1'b0;
    repeat (2) tick();
    checks++;
    if (lnk.free_outbound !== 1'b0 || lnk.pkt_out_valid !== 1'b0 || lnk.pkt_out !== 32'h0 ||
        proto_err !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got free=%b valid=%b pkt=%h perr=%b drop=%b exp all 0",
               lnk.free_outbound, lnk.pkt_out_valid, lnk.pkt_out, proto_err, drop);
    end
    rst_b = 1'b1;
    #1;
    checks++;
    if (lnk.free_outbound !== 1'b0) begin
      errors++;
      $display("FAIL reset_free_before_clk got %b exp 0", lnk.free_outbound);
    end
    tick();
    checks++;
    if (lnk.free_outbound !== 1'b1) begin
      errors++;
      $display("FAIL reset_free_rise got %b exp 1", lnk.free_outbound);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = proto_cnt;
    lnk.pkt_out_ready = 1'b1;
    send_pkt(32'h35ABCDEF);
    checks++;
    if (lnk.pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early got valid=%b exp 0", lnk.pkt_out_valid);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'h35ABCDEF) begin
      errors++;
      $display("FAIL single_pkt got valid=%b pkt=%h exp 1 35abcdef", lnk.pkt_out_valid, lnk.pkt_out);
    end
    checks++;
    if (lnk.pkt_out.source_id !== 4'h3 || lnk.pkt_out.dest_id !== 4'h5 ||
        lnk.pkt_out.data !== 24'hABCDEF) begin
      errors++;
      $display("FAIL single_fields got src=%h dst=%h data=%h exp 3 5 abcdef",
               lnk.pkt_out.source_id, lnk.pkt_out.dest_id, lnk.pkt_out.data);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b0 || proto_cnt != p0) begin
      errors++;
      $display("FAIL single_pop got valid=%b perr_pulses=%0d exp 0 %0d",
               lnk.pkt_out_valid, proto_cnt, p0);
    end
  endtask

  task automatic test_stall();
    int p0;
    p0 = proto_cnt;
    lnk.pkt_out_ready = 1'b1;
    send_byte(8'h12);
    repeat (3) tick();
    send_byte(8'h34);
    send_byte(8'h56);
    tick();
    send_byte(8'h78);
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'h12345678) begin
      errors++;
      $display("FAIL stall_pkt got valid=%b pkt=%h exp 1 12345678", lnk.pkt_out_valid, lnk.pkt_out);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b0 || proto_cnt != p0 || drop_cnt != 0) begin
      errors++;
      $display("FAIL stall_side got valid=%b perr=%0d drop=%0d exp 0 %0d 0",
               lnk.pkt_out_valid, proto_cnt, drop_cnt, p0);
    end
  endtask

  task automatic test_full();
    logic [31:0] pk [4];
    pk[0] = 32'hA0000001;
    pk[1] = 32'hB0000002;
    pk[2] = 32'hC0000003;
    pk[3] = 32'hD0000004;
    lnk.pkt_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(pk[i]);
    checks++;
    if (lnk.free_outbound !== 1'b1) begin
      errors++;
      $display("FAIL full_free_before_4th got %b exp 1", lnk.free_outbound);
    end
    send_byte(pk[3][31:24]);
    checks++;
    if (lnk.free_outbound !== 1'b0) begin
      errors++;
      $display("FAIL full_free_after_4th_byte0 got %b exp 0", lnk.free_outbound);
    end
    send_byte(pk[3][23:16]);
    send_byte(pk[3][15:8]);
    send_byte(pk[3][7:0]);
    tick();
    send_byte(8'h55);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL full_proto_err got %b exp 1", proto_err);
    end
    tick();
    checks++;
    if (proto_err !== 1'b0 || lnk.free_outbound !== 1'b0 || lnk.pkt_out !== pk[0]) begin
      errors++;
      $display("FAIL full_hold got perr=%b free=%b pkt=%h exp 0 0 %h",
               proto_err, lnk.free_outbound, lnk.pkt_out, pk[0]);
    end
    lnk.pkt_out_ready = 1'b1;
    tick();
    checks++;
    if (lnk.free_outbound !== 1'b1) begin
      errors++;
      $display("FAIL full_free_after_pop got %b exp 1", lnk.free_outbound);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== pk[i]) begin
        errors++;
        $display("FAIL full_order_%0d got valid=%b pkt=%h exp 1 %h", i, lnk.pkt_out_valid, lnk.pkt_out, pk[i]);
      end
      tick();
    end
    checks++;
    if (lnk.pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drained got valid=%b exp 0", lnk.pkt_out_valid);
    end
  endtask

  task automatic test_simul_push_pop();
    lnk.pkt_out_ready = 1'b0;
    send_pkt(32'h1A2B3C4D);
    tick();
    send_pkt(32'h5E6F7081);
    lnk.pkt_out_ready = 1'b1;
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'h1A2B3C4D) begin
      errors++;
      $display("FAIL simul_first got valid=%b pkt=%h exp 1 1a2b3c4d", lnk.pkt_out_valid, lnk.pkt_out);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'h5E6F7081 || lnk.free_outbound !== 1'b1) begin
      errors++;
      $display("FAIL simul_second got valid=%b pkt=%h free=%b exp 1 5e6f7081 1",
               lnk.pkt_out_valid, lnk.pkt_out, lnk.free_outbound);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_drained got valid=%b exp 0", lnk.pkt_out_valid);
    end
    lnk.pkt_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    lnk.pkt_out_ready = 1'b0;
    send_pkt(32'h99887766);
    tick();
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_b = 1'b0;
    #1;
    checks++;
    if (lnk.free_outbound !== 1'b0 || lnk.pkt_out_valid !== 1'b0 || lnk.pkt_out !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got free=%b valid=%b pkt=%h exp 0 0 0",
               lnk.free_outbound, lnk.pkt_out_valid, lnk.pkt_out);
    end
    tick();
    rst_b = 1'b1;
    tick();
    lnk.pkt_out_ready = 1'b1;
    send_pkt(32'hDEADBEEF);
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rstmid_fresh got valid=%b pkt=%h exp 1 deadbeef", lnk.pkt_out_valid, lnk.pkt_out);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale got valid=%b pkt=%h exp 0", lnk.pkt_out_valid, lnk.pkt_out);
    end
  endtask

`ifdef ROUTER_INGRESS_TIMEOUT_EN
  task automatic test_timeout();
    int d0;
    d0 = drop_cnt;
    lnk.pkt_out_ready = 1'b1;
    send_byte(8'h77);
    repeat (15) tick();
    checks++;
    if (drop !== 1'b0 || lnk.free_outbound !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early got drop=%b free=%b exp 0 1", drop, lnk.free_outbound);
    end
    tick();
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drop got %b exp 1", drop);
    end
    tick();
    send_pkt(32'h0F0F0F0F);
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b1 || lnk.pkt_out !== 32'h0F0F0F0F || drop_cnt != d0 + 1) begin
      errors++;
      $display("FAIL timeout_next got valid=%b pkt=%h drops=%0d exp 1 0f0f0f0f %0d",
               lnk.pkt_out_valid, lnk.pkt_out, drop_cnt, d0 + 1);
    end
    tick();
    checks++;
    if (lnk.pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_extra got valid=%b pkt=%h exp 0", lnk.pkt_out_valid, lnk.pkt_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full();
    test_simul_push_pop();
    test_reset_mid();
`ifdef ROUTER_INGRESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_ingress_port.md
Name: router_ingress_port

Overview:
- Router-side receiver for one endpoint's outbound byte link.
- Consumes the endpoint->router transaction (free_outbound / put_outbound / payload_outbound).
- Reassembles four 8-bit payload bytes into one 32-bit pkt_t (sourceID, destID, data) and buffers completed packets in a small FIFO.
- Presents buffered packets to the router switch core over a valid/ready interface.

Parameters:
- DEPTH, 4, packet FIFO depth in whole packets (power of two, >=2).
- TIMEOUT, 16, stall cycles before a partial packet is discarded (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_b  input  1  reset; asynchronous assertion, active-low.
- free_outbound  output  1  router can accept one more complete packet.
- put_outbound  input  1  endpoint drives a valid byte this cycle.
- payload_outbound  input  8  byte from endpoint.
- pkt_out  output  32  head-of-FIFO packet (pkt_t).
- pkt_out_valid  output  1  pkt_out holds a valid packet.
- pkt_out_ready  input  1  switch core consumes pkt_out this cycle.
- proto_err  output  1  one-cycle pulse on protocol violation.
- drop  output  1  one-cycle pulse when a partial packet is discarded (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: all outputs 0, FIFO empty, byte index 0, state IDLE. free_outbound rises on the first clock after rst_b deasserts. Reset mid-packet discards the partial packet and all FIFO contents.
- Byte order: byte0 = pkt[31:24] ({sourceID,destID}), byte1 = [23:16], byte2 = [15:8], byte3 = [7:0].
- Reservation: reserved = fifo_count + (state==RECV). free_outbound = (reserved < DEPTH). It is driven from flops and its next value is recomputed each cycle, including same-cycle push/pop.
- Start rule: the endpoint may assert put with byte0 only in a cycle where free_outbound is 1.
  - A put in IDLE while free_outbound==0 is ignored.
  - That put pulses proto_err the next cycle.
- FSM:
  - IDLE: put & free -> capture byte0, index=1, go RECV.
  - RECV: put -> capture byte[index], index++. put with index==3 -> push assembled packet into FIFO, go IDLE.
  - put low in RECV is a stall: no capture, index held.
- Back-to-back: a new byte0 in the cycle right after a byte3 is legal if free_outbound is 1 in that cycle.
- Latency: byte3 sampled at edge N -> pkt_out_valid=1 after edge N+1 when the FIFO was empty (registered FIFO, show-ahead head).
- Output handshake:
  - Pop on pkt_out_valid & pkt_out_ready.
  - pkt_out is stable while valid & !ready.
  - ready with valid low has no effect.
- FIFO push and pop in the same cycle are both honoured: count unchanged, pointers wrap modulo DEPTH.
- Full: push never overflows, because the reservation guarantees a slot. An overflow attempt is an assertion failure in simulation.

Optional Feature:
- Macro: ROUTER_INGRESS_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive put-low cycles in RECV.
  - When it reaches TIMEOUT, the partial packet is discarded, the FSM goes IDLE with index=0, and drop pulses for one cycle.
  - The freed reservation makes free_outbound re-evaluate the next cycle.
  - The counter clears on any put.
- Undefined: stalls are unbounded, no counter logic exists, and drop is tied 0.

Decomposition:
- Shared package router_pkg:
  - pkt_t typedef (sourceID[3:0], destID[3:0], data[23:0]).
  - localparam BYTES_PER_PKT=4.
  - Byte-index typedef (2 bits).
  - FSM state enum {IDLE, RECV}.
- Sub-module pkt_fifo: parameterised on DEPTH and pkt_t. Ports are push, push_data, pop, head, count, empty, full.
- Reassembly FSM and free logic stay in router_ingress_port.

Test Plan:
- Single packet: free=1, put bytes 0x35,0xAB,0xCD,0xEF on 4 consecutive cycles, ready=1 -> pkt_out=0x35ABCDEF (sourceID=3, destID=5, data=0xABCDEF), valid one cycle after the last byte, valid for 1 cycle.
- Stall mid-packet: bytes 0x12, gap 3 cycles, 0x34,0x56, gap 1, 0x78 -> pkt_out=0x12345678, no proto_err, no drop.
- Backpressure/full, DEPTH=4, ready=0:
  - Send 4 packets -> free_outbound drops to 0 the cycle after the 4th byte0.
  - A 5th byte0 is ignored and proto_err pulses.
  - Raise ready -> packets pop in order and free returns 1 the cycle after the first pop.
- Simultaneous push/pop: FIFO holds 1 packet, ready=1 during byte3 of the next -> count stays 1, both packets delivered in order with no bubble beyond 1 cycle.
- Reset mid-packet: assert rst_b=0 after byte1 -> outputs 0 immediately, then a fresh 4-byte packet 0xDEADBEEF is received correctly.
- With ROUTER_INGRESS_TIMEOUT_EN, TIMEOUT=16: byte0 then 16 idle cycles -> drop pulses once. The next packet 0x0F0F0F0F is received intact and the partial byte never appears.
